// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the two-channel input debouncer.
// Optional edge-pulse outputs are enabled with DEBOUNCE_EDGE_PULSE_EN.
package debounce_pkg;

  // 10 ms at 100 MHz.
  localparam int unsigned DefaultDebounceCycles = 1000000;
  localparam int unsigned DefaultSyncStages     = 2;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } debounce_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter and four-state FSM.
// With DEBOUNCE_EDGE_PULSE_EN defined, also emits one-cycle rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic out_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  debounce_state_e        state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   out_q, out_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        // Any low sample rejects the candidate and restarts the count.
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          out_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  assign out_o = out_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q, fall_q;

  // Registered alongside out_q so each pulse lines up with the new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels feeding the gate inputs in_a / in_b.
// Define DEBOUNCE_EDGE_PULSE_EN to add rise_a/rise_b/fall_a/fall_b pulse outputs.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned SYNC_STAGES     = DefaultSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise_a,
  output logic rise_b,
  output logic fall_a,
  output logic fall_b,
`endif
  output logic out_a,
  output logic out_b
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_a),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise_o(rise_a),
    .fall_o(fall_a),
`endif
    .out_o (out_a)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn_b),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise_o(rise_b),
    .fall_o(fall_b),
`endif
    .out_o (out_b)
  );

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed plan plus random bounce against a run-length model.
// Also checks the edge pulses when DEBOUNCE_EDGE_PULSE_EN is defined.
module tb_input_debouncer;

  localparam int unsigned Cycles = 8;
  localparam int unsigned Sync   = 2;

  logic clk;
  logic rst;
  logic btn_a;
  logic btn_b;
  logic out_a;
  logic out_b;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_a, rise_b, fall_a, fall_b;
`endif

  input_debouncer #(
    .DEBOUNCE_CYCLES(Cycles),
    .SYNC_STAGES    (Sync)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_a (btn_a),
    .btn_b (btn_b),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise_a(rise_a),
    .rise_b(rise_b),
    .fall_a(fall_a),
    .fall_b(fall_b),
`endif
    .out_a (out_a),
    .out_b (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the level the FSM sees at an edge is the raw value sampled
  // Sync edges earlier; the output takes a new level once that seen value has
  // been constant for Cycles+1 consecutive edges.
  bit [Sync-1:0] m_sync [2];
  bit            m_run_val [2];
  int            m_run_len [2];
  bit            m_out [2];
  bit            m_rise [2];
  bit            m_fall [2];

  task automatic model_step(input int c, input bit r, input bit raw);
    bit seen;
    m_rise[c] = 1'b0;
    m_fall[c] = 1'b0;
    if (r) begin
      m_sync[c]    = '0;
      m_run_val[c] = 1'b0;
      m_run_len[c] = 1;
      m_out[c]     = 1'b0;
    end else begin
      seen      = m_sync[c][Sync-1];
      m_sync[c] = {m_sync[c][Sync-2:0], raw};
      if (seen == m_run_val[c]) m_run_len[c]++;
      else begin
        m_run_val[c] = seen;
        m_run_len[c] = 1;
      end
      if (m_run_len[c] >= int'(Cycles) + 1 && m_run_val[c] != m_out[c]) begin
        m_out[c]  = m_run_val[c];
        m_rise[c] = m_run_val[c];
        m_fall[c] = !m_run_val[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rst, btn_a);
    model_step(1, rst, btn_b);
    #1;
    check_eq("out_a", int'(out_a), int'(m_out[0]));
    check_eq("out_b", int'(out_b), int'(m_out[1]));
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check_eq("rise_a", int'(rise_a), int'(m_rise[0]));
    check_eq("rise_b", int'(rise_b), int'(m_rise[1]));
    check_eq("fall_a", int'(fall_a), int'(m_fall[0]));
    check_eq("fall_b", int'(fall_b), int'(m_fall[1]));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Ticks until the chosen output shows `level`; returns edges counted, -1 on timeout.
  task automatic wait_level(input int ch, input bit level, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((ch == 0 ? out_a : out_b) == level) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, lat_a, lat_b;
  bit saw;
  bit [3:0] seg;
  int hold_a, hold_b;

  initial begin
    rst   = 1'b1;
    btn_a = 1'b1;
    btn_b = 1'b1;

    // Reset held for 3 edges with both buttons high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_out_a", int'(out_a), 0);
      check_eq("rst_out_b", int'(out_b), 0);
    end
    rst = 1'b0;
    tick();
    check_eq("post_rst_out_a", int'(out_a), 0);
    check_eq("post_rst_out_b", int'(out_b), 0);
    btn_a = 1'b0;
    btn_b = 1'b0;
    idle(25);

    // Clean press on A: new level 10 edges after the first sampling edge.
    btn_a = 1'b1;
    wait_level(0, 1'b1, lat);
    check_eq("press_latency_a", lat - 1, int'(Sync + Cycles));
    check_eq("press_b_quiet", int'(out_b), 0);
    btn_a = 1'b0;
    idle(25);

    // Bounce 1,0,1,0 in 3-cycle segments, then low: A never moves.
    saw = 1'b0;
    seg = 4'b0101;
    for (int k = 3; k >= 0; k--) begin
      btn_a = seg[k];
      for (int j = 0; j < 3; j++) begin
        tick();
        if (out_a) saw = 1'b1;
      end
    end
    btn_a = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (out_a) saw = 1'b1;
    end
    check_eq("bounce_a_no_change", int'(saw), 0);

    // B high 5, low 1, then high for good.
    btn_b = 1'b1;
    idle(5);
    btn_b = 1'b0;
    idle(1);
    btn_b = 1'b1;
    wait_level(1, 1'b1, lat);
    check_eq("settle_latency_b", lat - 1, int'(Sync + Cycles));

    // Both high and stable, then released together.
    btn_a = 1'b1;
    idle(25);
    check_eq("both_high_a", int'(out_a), 1);
    check_eq("both_high_b", int'(out_b), 1);
    btn_a = 1'b0;
    btn_b = 1'b0;
    lat_a = -1;
    lat_b = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!out_a && lat_a < 0) lat_a = i;
      if (!out_b && lat_b < 0) lat_b = i;
      if (lat_a >= 0 && lat_b >= 0) break;
    end
    check_eq("release_latency_a", lat_a - 1, int'(Sync + Cycles));
    check_eq("release_latency_b", lat_b - 1, int'(Sync + Cycles));
    idle(5);

    // Reset in the middle of A's count (count reaches 5 on the 8th edge).
    btn_a = 1'b1;
    idle(8);
    rst = 1'b1;
    tick();
    check_eq("midcount_rst_out_a", int'(out_a), 0);
    rst = 1'b0;
    wait_level(0, 1'b1, lat);
    check_eq("post_rst_latency_a", lat - 1, int'(Sync + Cycles));
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check_eq("post_rst_rise_a", int'(rise_a), 1);
    tick();
    check_eq("post_rst_rise_a_clear", int'(rise_a), 0);
`endif
    btn_a = 1'b0;
    idle(25);

    // Random bouncing with occasional resets.
    hold_a = 1;
    hold_b = 1;
    for (int i = 0; i < 3000; i++) begin
      if (--hold_a <= 0) begin
        btn_a  = 1'($urandom_range(0, 1));
        hold_a = int'($urandom_range(1, 14));
      end
      if (--hold_b <= 0) begin
        btn_b  = 1'($urandom_range(0, 1));
        hold_b = int'($urandom_range(1, 14));
      end
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got %0d, expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
